combo_key_seq: RTL and testbench

Parametrised multi-channel sequencer for synthetic modifier+key combos (Backspace→CTRL+LEFT, F6→SHIFT+F1, …) on the QL keyboard matrix path. Per channel it asserts the modifier first, asserts the main key after a programmable number of slow ticks, and on release drops the key before the modifier after a second programmable tick count. Sits between the PS/2 decode (`req` levels) and the matrix OR stage; the matrix bit mapping stays outside this block.

---
 rtl/combo_pkg.sv | 11 +
 rtl/combo_chan.sv | 35 +++
 rtl/combo_key_seq.sv | 33 +++
 tb/tb_combo_key_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/combo_pkg.sv
// combo_pkg: shared state encodings, counter width and default tick counts for the combo key sequencer
package combo_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t PRE  = 2'd1;
  localparam state_t ACT  = 2'd2;
  localparam state_t POST = 2'd3;
  localparam int CNT_W = 8;
  localparam int PRESS_TICKS_DEF = 15;
  localparam int REL_TICKS_DEF = 2;
endpackage

// File: rtl/combo_chan.sv
// combo_chan: one combo channel FSM (modifier leads/trails key by tick counts); in clk, delay_reset, tick, req, grant; out mod_act, key_act
module combo_chan import combo_pkg::*; #(
  parameter int PRESS_TICKS = PRESS_TICKS_DEF,
  parameter int REL_TICKS = REL_TICKS_DEF
) (
  input  logic clk,
  input  logic delay_reset,
  input  logic tick,
  input  logic req,
  input  logic grant,
  output logic mod_act,
  output logic key_act
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = (state_q == IDLE) ? (grant ? PRE : IDLE) :
              (state_q == PRE)  ? (!req ? IDLE : (cnt_q == CNT_W'(PRESS_TICKS)) ? ACT : PRE) :
              (state_q == ACT)  ? (req ? ACT : (REL_TICKS == 0) ? IDLE : POST) :
              (cnt_q == CNT_W'(REL_TICKS)) ? IDLE : POST;
    cnt_d = (state_d != state_q) ? '0 :
            (tick && cnt_q != '1 && (state_q == PRE || state_q == POST)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge delay_reset) begin
    if (delay_reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign mod_act = state_q != IDLE;
  assign key_act = state_q == ACT;
endmodule

// File: rtl/combo_key_seq.sv
// combo_key_seq: multi-channel modifier+key combo sequencer; in clk, delay_reset, tick, req[CHANNELS]; out mod_act, key_act, busy; COMBO_ARB_EN adds single-active arbiter
module combo_key_seq import combo_pkg::*; #(
  parameter int CHANNELS = 12,
  parameter int PRESS_TICKS = PRESS_TICKS_DEF,
  parameter int REL_TICKS = REL_TICKS_DEF
) (
  input  logic                clk,
  input  logic                delay_reset,
  input  logic                tick,
  input  logic [CHANNELS-1:0] req,
  output logic [CHANNELS-1:0] mod_act,
  output logic [CHANNELS-1:0] key_act,
  output logic                busy
);
  logic [CHANNELS-1:0] grant;
`ifdef COMBO_ARB_EN
  assign grant = busy ? '0 : req & (~req + CHANNELS'(1));
`else
  assign grant = req;
`endif
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    combo_chan #(.PRESS_TICKS(PRESS_TICKS), .REL_TICKS(REL_TICKS)) u_chan (
      .clk(clk),
      .delay_reset(delay_reset),
      .tick(tick),
      .req(req[i]),
      .grant(grant[i]),
      .mod_act(mod_act[i]),
      .key_act(key_act[i])
    );
  end
  assign busy = |mod_act;
endmodule

// File: tb/tb_combo_key_seq.sv
// tb_combo_key_seq: directed scoreboard bench for combo_key_seq (default and REL_TICKS=0 instances)
module tb_combo_key_seq;
  logic clk = 0;
  logic delay_reset = 1;
  logic tick = 0;
  logic [11:0] req = '1;
  logic [11:0] req0 = '0;
  logic [11:0] mod_act, key_act, mod0, key0;
  logic busy, busy0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int cyc;
    int dut;
    string tag;
    logic [11:0] mod;
    logic [11:0] key;
    logic bsy;
  } exp_t;
  exp_t q[$];
  combo_key_seq dut (
    .clk(clk), .delay_reset(delay_reset), .tick(tick), .req(req),
    .mod_act(mod_act), .key_act(key_act), .busy(busy)
  );
  combo_key_seq #(.REL_TICKS(0)) dut0 (
    .clk(clk), .delay_reset(delay_reset), .tick(tick), .req(req0),
    .mod_act(mod0), .key_act(key0), .busy(busy0)
  );
  always #5 clk = ~clk;
  function automatic int next_tick(input int e);
    return e + 4 - (e % 4);
  endfunction
  task automatic push(input int c, input int d, input string t, input logic [11:0] m, input logic [11:0] k, input logic b);
    exp_t e;
    e.cyc = c;
    e.dut = d;
    e.tag = t;
    e.mod = m;
    e.key = k;
    e.bsy = b;
    q.push_back(e);
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      tick = ((cyc + 1) % 4 == 0);
    end
  endtask
  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask
  task automatic expect_press(input int d, input logic [11:0] m, output int act);
    int p;
    int t;
    p = cyc + 1;
    t = next_tick(p) + 56;
    push(p, d, "pre_enter", m, '0, 1'b1);
    push(t, d, "pre_last", m, '0, 1'b1);
    push(t + 1, d, "act_enter", m, m, 1'b1);
    act = t + 1;
  endtask
  task automatic expect_release(input int d, input logic [11:0] m, output int idle);
    int p;
    int r;
    p = cyc + 1;
    if (d == 1) begin
      push(p, d, "rel0_idle", '0, '0, 1'b0);
      idle = p;
    end else begin
      r = next_tick(p) + 4;
      push(p, d, "post_enter", m, '0, 1'b1);
      push(r, d, "post_last", m, '0, 1'b1);
      push(r + 1, d, "post_idle", '0, '0, 1'b0);
      idle = r + 1;
    end
  endtask
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [11:0] om, ok;
      logic ob;
      e = q.pop_front();
      om = (e.dut == 1) ? mod0 : mod_act;
      ok = (e.dut == 1) ? key0 : key_act;
      ob = (e.dut == 1) ? busy0 : busy;
      checks++;
      assert (e.cyc == cyc) else begin
        errors++;
        $error("FAIL %s stale: checked at cycle %0d, wanted cycle %0d", e.tag, cyc, e.cyc);
      end
      checks++;
      assert (om === e.mod) else begin
        errors++;
        $error("FAIL %s@%0d mod_act got %h want %h", e.tag, cyc, om, e.mod);
      end
      checks++;
      assert (ok === e.key) else begin
        errors++;
        $error("FAIL %s@%0d key_act got %h want %h", e.tag, cyc, ok, e.key);
      end
      checks++;
      assert (ob === e.bsy) else begin
        errors++;
        $error("FAIL %s@%0d busy got %b want %b", e.tag, cyc, ob, e.bsy);
      end
    end
  end
  initial begin
    int act;
    int idle;
    int k;
    step(3);
    push(cyc, 0, "reset", '0, '0, 1'b0);
    push(cyc, 1, "reset0", '0, '0, 1'b0);
    req = '0;
    step(1);
    delay_reset = 0;
    step(1);
    req[1] = 1'b1;
    push(cyc, 0, "pre_idle", '0, '0, 1'b0);
    expect_press(0, 12'h002, act);
    run_to(cyc + 200);
    req[1] = 1'b0;
    push(cyc, 0, "act_hold", 12'h002, 12'h002, 1'b1);
    expect_release(0, 12'h002, idle);
    run_to(idle + 2);
    req[3] = 1'b1;
    k = cyc;
    push(k + 1, 0, "tap_pre", 12'h008, '0, 1'b1);
    run_to(k + 10);
    push(cyc, 0, "tap_mid", 12'h008, '0, 1'b1);
    run_to(k + 20);
    req[3] = 1'b0;
    push(cyc, 0, "tap_hold", 12'h008, '0, 1'b1);
    push(cyc + 1, 0, "tap_idle", '0, '0, 1'b0);
    step(3);
    req0[0] = 1'b1;
    expect_press(1, 12'h001, act);
    run_to(act + 3);
    req0[0] = 1'b0;
    push(cyc, 1, "rel0_act", 12'h001, 12'h001, 1'b1);
    expect_release(1, 12'h001, idle);
    run_to(idle + 2);
    req[1] = 1'b1;
    expect_press(0, 12'h002, act);
    run_to(act + 2);
    #2;
    delay_reset = 1;
    push(cyc, 0, "rst_async", '0, '0, 1'b0);
    step(1);
    push(cyc, 0, "rst_hold", '0, '0, 1'b0);
    delay_reset = 0;
    expect_press(0, 12'h002, act);
    run_to(act + 1);
    req[1] = 1'b0;
    expect_release(0, 12'h002, idle);
    run_to(idle + 2);
    req[2] = 1'b1;
    req[5] = 1'b1;
`ifdef COMBO_ARB_EN
    expect_press(0, 12'h004, act);
    run_to(act + 1);
    req[2] = 1'b0;
    expect_release(0, 12'h004, idle);
    run_to(idle);
    expect_press(0, 12'h020, act);
    run_to(act + 1);
    req[5] = 1'b0;
    expect_release(0, 12'h020, idle);
    run_to(idle + 2);
`else
    expect_press(0, 12'h024, act);
    run_to(act + 1);
    req[2] = 1'b0;
    req[5] = 1'b0;
    expect_release(0, 12'h024, idle);
    run_to(idle + 2);
`endif
    step(2);
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL pending: %0d expectations left unchecked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
